// File: rtl/jtkunio_scr_romslot_pkg.sv
// ---------------------------------------------------------------------------
// jtkunio_scr_romslot_pkg
// Shared definitions for the kunio ROM slots (scroll, objects, characters).
//   - Fetch FSM state encoding (2 bits): IDLE, REQ, BEAT0, BEAT1.
//   - BURST: number of 16-bit beats per cache fill.
// ---------------------------------------------------------------------------
package jtkunio_scr_romslot_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_BEAT0 = 2'd2;
    localparam logic [1:0] ST_BEAT1 = 2'd3;

    // One fill is two consecutive 16-bit words, giving a 32-bit line.
    localparam int BURST = 2;

endpackage

// File: rtl/jtkunio_romslot_cache.sv
// ---------------------------------------------------------------------------
// jtkunio_romslot_cache
// One-entry cache line for a kunio ROM slot: tag, valid flag and 32-bit data,
// plus the combinational hit compare.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears everything)
//   clr          : invalidate the line (a new fill is starting)
//   wr_lo        : store din into dout[15:0]  (first beat)
//   wr_hi        : store din into dout[31:16], load fill_tag, set valid
//   fill_tag     : tag the line is filled under
//   din          : 16-bit beat from SDRAM
//   look_tag     : tag currently requested by the layer
//   hit          : valid && tag == look_tag
//   dout         : cached line {high word, low word}
// ---------------------------------------------------------------------------
module jtkunio_romslot_cache
    import jtkunio_scr_romslot_pkg::*;
#(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_lo,
    input  logic          wr_hi,
    input  logic [TW-1:0] fill_tag,
    input  logic [15:0]   din,
    input  logic [TW-1:0] look_tag,
    output logic          hit,
    output logic [31:0]   dout
);

    logic          valid;
    logic [TW-1:0] tag;

    // The line only becomes valid with the last beat, so a partially
    // filled line can never produce a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            dout  <= '0;
        end else begin
            if (clr) valid <= 1'b0;
            if (wr_lo) dout[15:0] <= din;
            if (wr_hi) begin
                dout[31:16] <= din;
                tag         <= fill_tag;
                valid       <= 1'b1;
            end
        end
    end

    assign hit = valid && (tag == look_tag);

endmodule

// File: rtl/jtkunio_scr_romslot.sv
// ---------------------------------------------------------------------------
// jtkunio_scr_romslot
// ROM-side responder for the scroll tile layer. Serves 32-bit reads from a
// one-entry cache; on a miss it fetches two consecutive 16-bit words from
// SDRAM through the req/ack/dst/rdy burst handshake.
//
// Handshake: sdram_req is raised with a stable sdram_addr and held until a
// one-cycle sdram_ack; req drops on the ack edge. Afterwards a beat is a
// cycle with data_dst && data_rdy; data_read carries the word. Beats outside
// BEAT0/BEAT1 are ignored, and ack wins if it coincides with a beat.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   slot_cs     : layer requests data
//   slot_addr   : 16-bit word address (bit 0 ignored)
//   slot_dout   : {word at addr+1, word at addr}
//   slot_ok     : slot_dout valid for current slot_addr (registered)
//   sdram_addr  : burst start address, OFFSET + even word address (wraps)
//   sdram_req   : fetch request
//   sdram_ack   : arbiter accepted request
//   data_dst    : beat for this slot on data_read
//   data_rdy    : beat valid
//   data_read   : SDRAM data beat
// ---------------------------------------------------------------------------
module jtkunio_scr_romslot
    import jtkunio_scr_romslot_pkg::*;
#(
    parameter int          AW     = 17,
    parameter int          SW     = 22,
    parameter logic [SW-1:0] OFFSET = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          slot_cs,
    input  logic [AW-1:0] slot_addr,
    output logic [31:0]   slot_dout,
    output logic          slot_ok,
    output logic [SW-1:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          data_dst,
    input  logic          data_rdy,
    input  logic [15:0]   data_read
);

    localparam int TW = AW - 1;

    logic [1:0]    st;
    logic [TW-1:0] ftag;
    logic [TW-1:0] look_tag;
    logic [SW-1:0] word_addr;
    logic          hit;
    logic          beat;
    logic          clr_valid;
    logic          wr_lo;
    logic          wr_hi;
    logic          start;
    logic          unused_addr_lsb;

    assign look_tag        = slot_addr[AW-1:1];
    assign unused_addr_lsb = slot_addr[0];
    assign word_addr       = SW'({look_tag, 1'b0});

    // Ack has priority over a beat on the same cycle.
    assign beat  = data_dst && data_rdy && !sdram_ack;
    assign start = (st == ST_IDLE) && slot_cs && !hit;

    assign clr_valid = start;
    assign wr_lo     = (st == ST_BEAT0) && beat;
    assign wr_hi     = (st == ST_BEAT1) && beat;

    jtkunio_romslot_cache #(.TW(TW)) u_cache (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_valid),
        .wr_lo    (wr_lo),
        .wr_hi    (wr_hi),
        .fill_tag (ftag),
        .din      (data_read),
        .look_tag (look_tag),
        .hit      (hit),
        .dout     (slot_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            ftag       <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
            slot_ok    <= 1'b0;
        end else begin
            // No bypass: a line completing in BEAT1 shows ok one edge later.
            slot_ok <= slot_cs && hit && (st == ST_IDLE);
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        ftag       <= look_tag;
                        sdram_addr <= OFFSET + word_addr;
                        sdram_req  <= 1'b1;
                        st         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        st        <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    if (beat) st <= ST_BEAT1;
                end
                ST_BEAT1: begin
                    // The fill completes under ftag even if the layer has
                    // moved on; the new address then misses in IDLE.
                    if (beat) st <= ST_IDLE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkunio_scr_romslot.sv
module tb_jtkunio_scr_romslot;

    logic        clk = 1'b0;
    logic        rst;
    logic        slot_cs;
    logic [16:0] slot_addr;
    logic [31:0] slot_dout;
    logic        slot_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        data_dst;
    logic        data_rdy;
    logic [15:0] data_read;

    // Second instance exercising address wrap with a high OFFSET.
    logic        b_cs;
    logic [16:0] b_addr;
    logic [31:0] b_dout;
    logic        b_ok;
    logic [21:0] b_sdram_addr;
    logic        b_req;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int req_seen;
    int ok_seen;

    always #5 clk = ~clk;

    jtkunio_scr_romslot dut (
        .clk        (clk),
        .rst        (rst),
        .slot_cs    (slot_cs),
        .slot_addr  (slot_addr),
        .slot_dout  (slot_dout),
        .slot_ok    (slot_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .data_dst   (data_dst),
        .data_rdy   (data_rdy),
        .data_read  (data_read)
    );

    jtkunio_scr_romslot #(.OFFSET(22'h3FFFF0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .slot_cs    (b_cs),
        .slot_addr  (b_addr),
        .slot_dout  (b_dout),
        .slot_ok    (b_ok),
        .sdram_addr (b_sdram_addr),
        .sdram_req  (b_req),
        .sdram_ack  (1'b0),
        .data_dst   (1'b0),
        .data_rdy   (1'b0),
        .data_read  (16'h0000)
    );

    // Inputs change 1 time unit after the rising edge; checks happen there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ack_pulse();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d);
        data_dst  = 1'b1;
        data_rdy  = 1'b1;
        data_read = d;
        tick();
        data_dst  = 1'b0;
        data_rdy  = 1'b0;
        data_read = 16'h0000;
    endtask

    initial begin
        rst = 1'b1; slot_cs = 1'b0; slot_addr = '0;
        sdram_ack = 1'b0; data_dst = 1'b0; data_rdy = 1'b0; data_read = '0;
        b_cs = 1'b1; b_addr = 17'h00020;
        tick(); tick();
        check("rst_ok",    {31'd0, slot_ok},    32'd0);
        check("rst_req",   {31'd0, sdram_req},  32'd0);
        check("rst_addr",  {10'd0, sdram_addr}, 32'd0);
        check("rst_dout",  slot_dout,           32'd0);
        rst = 1'b0;

        // First miss at 0xA40
        slot_cs = 1'b1; slot_addr = 17'h00A40;
        tick();
        check("miss_req",  {31'd0, sdram_req},  32'd1);
        check("miss_addr", {10'd0, sdram_addr}, 32'h000A40);
        check("wrap_req",  {31'd0, b_req},      32'd1);
        check("wrap_addr", {10'd0, b_sdram_addr}, 32'h000010);
        tick(); tick();
        check("req_hold",  {31'd0, sdram_req},  32'd1);
        check("addr_hold", {10'd0, sdram_addr}, 32'h000A40);
        ack_pulse();
        check("req_drop",  {31'd0, sdram_req},  32'd0);
        send_beat(16'h1234);
        send_beat(16'h5678);
        check("ok_late",   {31'd0, slot_ok},    32'd0);
        tick();
        check("ok_rise",   {31'd0, slot_ok},    32'd1);
        check("dout_1",    slot_dout,           32'h5678_1234);

        // Odd address in the same line still hits
        slot_addr = 17'h00A41;
        tick();
        check("odd_ok",    {31'd0, slot_ok},    32'd1);
        tick(); tick(); tick();
        check("odd_noreq", {31'd0, sdram_req},  32'd0);
        check("odd_dout",  slot_dout,           32'h5678_1234);

        // Address change while in BEAT0
        slot_addr = 17'h00A44;
        tick();
        check("a44_addr",  {10'd0, sdram_addr}, 32'h000A44);
        ack_pulse();
        slot_addr = 17'h00A42;
        send_beat(16'h1111);
        send_beat(16'h2222);
        check("stale_ok0", {31'd0, slot_ok},    32'd0);
        tick();
        check("stale_ok1", {31'd0, slot_ok},    32'd0);
        check("refetch_req",  {31'd0, sdram_req},  32'd1);
        check("refetch_addr", {10'd0, sdram_addr}, 32'h000A42);
        tick();
        ack_pulse();
        send_beat(16'h3333);
        send_beat(16'h4444);
        tick();
        check("a42_ok",    {31'd0, slot_ok},    32'd1);
        check("a42_dout",  slot_dout,           32'h4444_3333);

        // Reset while in BEAT1, then a stray beat
        slot_addr = 17'h00A80;
        tick();
        ack_pulse();
        send_beat(16'hAAAA);
        slot_cs = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_beat(16'hDEAD);
        check("rst_b1_req",  {31'd0, sdram_req}, 32'd0);
        check("rst_b1_ok",   {31'd0, slot_ok},   32'd0);
        check("rst_b1_dout", slot_dout,          32'd0);
        slot_cs = 1'b1;
        tick();
        check("rst_refetch_req",  {31'd0, sdram_req},  32'd1);
        check("rst_refetch_addr", {10'd0, sdram_addr}, 32'h000A80);

        // cs low with a miss address: nothing happens
        rst = 1'b1; slot_cs = 1'b0; slot_addr = 17'h01000;
        tick();
        rst = 1'b0;
        req_seen = 0; ok_seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (sdram_req) req_seen++;
            if (slot_ok)   ok_seen++;
        end
        check("idle_req_cycles", req_seen, 32'd0);
        check("idle_ok_cycles",  ok_seen,  32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
